// File: rtl/game_screen_compositor.sv
// Game screen compositor: START/PLAY/WIN/LOSE screen FSM, prioritised sprite
// layer mux with border and camera background, and a per-transition fade-in.
// Pixel path is a fixed two-stage pipeline (select, then fade) with matching
// coordinate delay. The state outputs come straight from the state register.
module game_screen_compositor #(
    parameter int          N_LAYERS     = 6,
    parameter int          HEALTH_W     = 3,
    parameter int          FADE_STEPS   = 4,
    parameter int          BORDER_X     = 960,
    parameter int          BORDER_Y     = 640,
    parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
    parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
    parameter logic [31:0] RESTART_CODE = 32'h20DF_10EF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    input  logic                     nf_in,
    input  logic [31:0]              ir_in,
    input  logic                     attack_valid_in,
    input  logic [HEALTH_W-1:0]      player_health_in,
    input  logic [HEALTH_W-1:0]      opponent_health_in,
    input  logic [24*N_LAYERS-1:0]   layer_pixels_in,
    input  logic [N_LAYERS-1:0]      layer_valid_in,
    input  logic                     camera_en_in,
    input  logic [23:0]              camera_pixel_in,
    input  logic [23:0]              start_pixel_in,
    input  logic [23:0]              win_pixel_in,
    input  logic [23:0]              lose_pixel_in,
    output logic [23:0]              pixel_out,
    output logic [10:0]              hcount_out,
    output logic [9:0]               vcount_out,
    output logic [1:0]               game_state_out,
    output logic                     play_active_out
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } state_t;

    localparam logic [2:0]  FADE_LOAD = 3'(FADE_STEPS);
    localparam logic [10:0] BORDER_H  = 11'(BORDER_X);
    localparam logic [9:0]  BORDER_V  = 10'(BORDER_Y);

    state_t      state_q, state_d;
    logic        ever_attack_q, ever_attack_d;
    logic [2:0]  fade_cnt_q, fade_cnt_d;

    logic [23:0] layer_pixel;
    logic        layer_hit;
    logic        on_border;
    logic [23:0] sel_pixel;

    logic [23:0] s1_pixel;
    logic [2:0]  s1_fade;
    logic [10:0] s1_hcount;
    logic [9:0]  s1_vcount;

    // Control state: screen, attack-seen flag and fade counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_START;
            ever_attack_q <= 1'b0;
            fade_cnt_q    <= 3'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            ever_attack_q <= ever_attack_d;
            fade_cnt_q    <= fade_cnt_d;
        end
    end

    // Next-state, attack tracking and fade counter update.
    always_comb begin
        // NOTE: hold-current defaults first so no path leaves a latch behind.
        state_d       = state_q;
        ever_attack_d = ever_attack_q;
        fade_cnt_d    = fade_cnt_q;

        unique case (state_q)
            S_START: begin
                if (ir_in == START_CODE_A || ir_in == START_CODE_B)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                // Uses the registered flag: an attack lands one cycle later.
                if (ever_attack_q && player_health_in == '0 && opponent_health_in != '0)
                    state_d = S_LOSE;
                else if (ever_attack_q && opponent_health_in == '0 && player_health_in != '0)
                    state_d = S_WIN;
            end
            S_WIN, S_LOSE: begin
                if (ir_in == RESTART_CODE)
                    state_d = S_START;
            end
        endcase

        if (state_q == S_PLAY && attack_valid_in)
            ever_attack_d = 1'b1;
        if (state_d == S_START && state_q != S_START)
            ever_attack_d = 1'b0;

        // A screen change reloads the fade and wins over a same-cycle frame tick.
        if (state_d != state_q)
            fade_cnt_d = FADE_LOAD;
        else if (nf_in && fade_cnt_q != 3'd0)
            fade_cnt_d = fade_cnt_q - 3'd1;
    end

    // Highest-priority opaque layer: scan downward so the lowest index wins.
    always_comb begin
        layer_pixel = '0;
        layer_hit   = 1'b0;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (layer_valid_in[k]) begin
                layer_pixel = layer_pixels_in[24*k +: 24];
                layer_hit   = 1'b1;
            end
        end
    end

    assign on_border = (hcount_in == BORDER_H && vcount_in <= BORDER_V) ||
                       (vcount_in == BORDER_V && hcount_in <= BORDER_H);

    // Screen-dependent source select.
    always_comb begin
        sel_pixel = '0;
        unique case (state_q)
            S_START: sel_pixel = start_pixel_in;
            S_WIN:   sel_pixel = win_pixel_in;
            S_LOSE:  sel_pixel = lose_pixel_in;
            S_PLAY: begin
                if (on_border)
                    sel_pixel = 24'hFFFFFF;
                else if (layer_hit)
                    sel_pixel = layer_pixel;
                else if (camera_en_in)
                    sel_pixel = camera_pixel_in;
            end
        endcase
    end

    // Stage 1: register selected pixel, its fade depth and coordinates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_pixel  <= '0;
            s1_fade   <= '0;
            s1_hcount <= '0;
            s1_vcount <= '0;
        end else begin
            s1_pixel  <= sel_pixel;
            s1_fade   <= fade_cnt_q;
            s1_hcount <= hcount_in;
            s1_vcount <= vcount_in;
        end
    end

    // Stage 2: halve each channel once per remaining fade step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_out  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            pixel_out  <= {s1_pixel[23:16] >> s1_fade,
                           s1_pixel[15:8]  >> s1_fade,
                           s1_pixel[7:0]   >> s1_fade};
            hcount_out <= s1_hcount;
            vcount_out <= s1_vcount;
        end
    end

    assign game_state_out  = state_q;
    assign play_active_out = (state_q == S_PLAY);

endmodule

// File: tb/tb_game_screen_compositor.sv
// Bench for game_screen_compositor: a frame-level behavioural model compared
// against the DUT after every clock edge, plus directed literal checks.
module tb_game_screen_compositor;

    localparam int          N_LAYERS     = 6;
    localparam int          HEALTH_W     = 3;
    localparam int          FADE_STEPS   = 4;
    localparam logic [31:0] START_CODE_A = 32'h20DF_5BA4;
    localparam logic [31:0] START_CODE_B = 32'h20DF_5AA5;
    localparam logic [31:0] RESTART_CODE = 32'h20DF_10EF;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;
    logic                   nf_in;
    logic [31:0]            ir_in;
    logic                   attack_valid_in;
    logic [HEALTH_W-1:0]    player_health_in;
    logic [HEALTH_W-1:0]    opponent_health_in;
    logic [24*N_LAYERS-1:0] layer_pixels_in;
    logic [N_LAYERS-1:0]    layer_valid_in;
    logic                   camera_en_in;
    logic [23:0]            camera_pixel_in;
    logic [23:0]            start_pixel_in;
    logic [23:0]            win_pixel_in;
    logic [23:0]            lose_pixel_in;
    logic [23:0]            pixel_out;
    logic [10:0]            hcount_out;
    logic [9:0]             vcount_out;
    logic [1:0]             game_state_out;
    logic                   play_active_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    game_screen_compositor #(
        .N_LAYERS   (N_LAYERS),
        .HEALTH_W   (HEALTH_W),
        .FADE_STEPS (FADE_STEPS)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .nf_in              (nf_in),
        .ir_in              (ir_in),
        .attack_valid_in    (attack_valid_in),
        .player_health_in   (player_health_in),
        .opponent_health_in (opponent_health_in),
        .layer_pixels_in    (layer_pixels_in),
        .layer_valid_in     (layer_valid_in),
        .camera_en_in       (camera_en_in),
        .camera_pixel_in    (camera_pixel_in),
        .start_pixel_in     (start_pixel_in),
        .win_pixel_in       (win_pixel_in),
        .lose_pixel_in      (lose_pixel_in),
        .pixel_out          (pixel_out),
        .hcount_out         (hcount_out),
        .vcount_out         (vcount_out),
        .game_state_out     (game_state_out),
        .play_active_out    (play_active_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;   // 0 START, 1 PLAY, 2 WIN, 3 LOSE
    int          m_ever  = 0;
    int          m_fade  = 0;
    logic [23:0] m_s1_pix = '0, m_out_pix = '0;
    logic [10:0] m_s1_h   = '0, m_out_h   = '0;
    logic [9:0]  m_s1_v   = '0, m_out_v   = '0;

    // What the screen should show for the current inputs, already faded.
    function automatic logic [23:0] model_pixel(input int st, input int fade);
        logic [23:0] p;
        bit          found;
        int          r, g, b;
        p = 24'h000000;
        found = 0;
        if (st == 0)      p = start_pixel_in;
        else if (st == 2) p = win_pixel_in;
        else if (st == 3) p = lose_pixel_in;
        else begin
            if ((hcount_in == 960 && vcount_in <= 640) || (vcount_in == 640 && hcount_in <= 960))
                p = 24'hFFFFFF;
            else begin
                for (int k = 0; k < N_LAYERS; k++) begin
                    if (!found && layer_valid_in[k]) begin
                        p = layer_pixels_in[24*k +: 24];
                        found = 1;
                    end
                end
                if (!found) p = camera_en_in ? camera_pixel_in : 24'h000000;
            end
        end
        r = int'(p[23:16]) / (1 << fade);
        g = int'(p[15:8])  / (1 << fade);
        b = int'(p[7:0])   / (1 << fade);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic model_advance();
        int ns;
        ns = m_state;
        case (m_state)
            0: if (ir_in == START_CODE_A || ir_in == START_CODE_B) ns = 1;
            1: begin
                if (m_ever == 1 && player_health_in == 0 && opponent_health_in != 0) ns = 3;
                else if (m_ever == 1 && opponent_health_in == 0 && player_health_in != 0) ns = 2;
            end
            default: if (ir_in == RESTART_CODE) ns = 0;
        endcase
        if (ns != m_state) m_fade = FADE_STEPS;
        else if (nf_in && m_fade > 0) m_fade = m_fade - 1;
        if (m_state == 1 && attack_valid_in) m_ever = 1;
        if (ns == 0 && m_state != 0) m_ever = 0;
        m_state = ns;
    endtask

    // Model step on every edge, then compare all outputs shortly after.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_state = 0; m_ever = 0; m_fade = 0;
            m_s1_pix = '0; m_out_pix = '0;
            m_s1_h = '0; m_out_h = '0;
            m_s1_v = '0; m_out_v = '0;
        end else begin
            m_out_pix = m_s1_pix;
            m_out_h   = m_s1_h;
            m_out_v   = m_s1_v;
            m_s1_pix  = model_pixel(m_state, m_fade);
            m_s1_h    = hcount_in;
            m_s1_v    = vcount_in;
            model_advance();
        end
        #1;
        check("model_pixel", pixel_out, m_out_pix);
        check("model_hcount", hcount_out, m_out_h);
        check("model_vcount", vcount_out, m_out_v);
        check("model_state", game_state_out, m_state[1:0]);
        check("model_play_active", play_active_out, (m_state == 1));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic frame();
        nf_in = 1'b1;
        @(negedge clk_in);
        nf_in = 1'b0;
    endtask

    logic [23:0] fade_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fade_exp[0] = 24'h1E1E1E;
        fade_exp[1] = 24'h3C3C3C;
        fade_exp[2] = 24'h787878;
        fade_exp[3] = 24'hF0F0F0;

        rst_in = 1'b1;
        hcount_in = 11'd100; vcount_in = 10'd50;
        nf_in = 1'b0; ir_in = 32'h0; attack_valid_in = 1'b0;
        player_health_in = 3'd3; opponent_health_in = 3'd3;
        layer_pixels_in = '0;
        layer_pixels_in[24*0 +: 24] = 24'hAAAAAA;
        layer_pixels_in[24*1 +: 24] = 24'h00FF00;
        layer_pixels_in[24*2 +: 24] = 24'hFF0000;
        layer_pixels_in[24*3 +: 24] = 24'h112233;
        layer_pixels_in[24*4 +: 24] = 24'h445566;
        layer_pixels_in[24*5 +: 24] = 24'h778899;
        layer_valid_in = '0;
        camera_en_in = 1'b1; camera_pixel_in = 24'h345678;
        start_pixel_in = 24'h123456; win_pixel_in = 24'h808080; lose_pixel_in = 24'hF0F0F0;

        cyc(1);
        check("reset_pixel", pixel_out, 24'h0);
        check("reset_state", game_state_out, 2'd0);
        cyc(1);
        rst_in = 1'b0;

        // Start screen: reset leaves no fade pending.
        cyc(3);
        check("start_no_fade", pixel_out, 24'h123456);
        repeat (FADE_STEPS + 1) begin frame(); cyc(1); end
        cyc(2);
        check("start_after_frames", pixel_out, 24'h123456);
        check("start_state", game_state_out, 2'd0);
        ir_in = RESTART_CODE; cyc(3);
        check("start_ignores_restart", game_state_out, 2'd0);

        // Enter PLAY.
        ir_in = START_CODE_B; cyc(1);
        check("play_entry", game_state_out, 2'd1);
        check("play_active", play_active_out, 1'b1);
        ir_in = 32'h0;
        layer_valid_in = 6'b000110;
        repeat (FADE_STEPS) begin frame(); cyc(1); end
        cyc(2);
        check("layer_priority", pixel_out, 24'h00FF00);

        // Border boundaries.
        hcount_in = 11'd960; vcount_in = 10'd100; cyc(2);
        check("border_vertical", pixel_out, 24'hFFFFFF);
        hcount_in = 11'd961; cyc(2);
        check("border_miss_x", pixel_out, 24'h00FF00);
        hcount_in = 11'd500; vcount_in = 10'd640; cyc(2);
        check("border_horizontal", pixel_out, 24'hFFFFFF);
        hcount_in = 11'd960; cyc(2);
        check("border_corner", pixel_out, 24'hFFFFFF);
        hcount_in = 11'd961; cyc(2);
        check("border_past_corner", pixel_out, 24'h00FF00);
        hcount_in = 11'd960; vcount_in = 10'd641; cyc(2);
        check("border_below", pixel_out, 24'h00FF00);
        hcount_in = 11'd100; vcount_in = 10'd50;

        // Layer / camera fallbacks.
        layer_valid_in = 6'b100001; cyc(2);
        check("layer0_wins", pixel_out, 24'hAAAAAA);
        layer_valid_in = 6'b100000; cyc(2);
        check("layer5_only", pixel_out, 24'h778899);
        layer_valid_in = 6'b000000; cyc(2);
        check("camera_bg", pixel_out, 24'h345678);
        camera_en_in = 1'b0; cyc(2);
        check("black_bg", pixel_out, 24'h000000);
        camera_en_in = 1'b1; layer_valid_in = 6'b000110;

        // PLAY ignores IR; no win before any attack.
        ir_in = RESTART_CODE; cyc(3);
        check("play_ignores_ir", game_state_out, 2'd1);
        ir_in = 32'h0;
        player_health_in = 3'd3; opponent_health_in = 3'd0; cyc(3);
        check("no_attack_no_win", game_state_out, 2'd1);
        attack_valid_in = 1'b1; cyc(1); attack_valid_in = 1'b0;
        check("attack_registered", game_state_out, 2'd1);
        cyc(1);
        check("win_after_attack", game_state_out, 2'd2);
        cyc(2);
        check("win_faded", pixel_out, 24'h080808);

        // Restart with a same-cycle frame tick: load beats decrement.
        ir_in = RESTART_CODE; nf_in = 1'b1; cyc(1);
        nf_in = 1'b0; ir_in = 32'h0;
        check("restart_state", game_state_out, 2'd0);
        cyc(2);
        check("restart_fade_load", pixel_out, 24'h010305);

        // ever_attack cleared by the restart.
        ir_in = START_CODE_A; cyc(1); ir_in = 32'h0;
        check("replay_entry", game_state_out, 2'd1);
        cyc(3);
        check("ever_attack_cleared", game_state_out, 2'd1);

        // Draw stays in PLAY, then lose.
        player_health_in = 3'd0; opponent_health_in = 3'd0;
        attack_valid_in = 1'b1; cyc(1); attack_valid_in = 1'b0;
        cyc(3);
        check("draw_stays_play", game_state_out, 2'd1);
        opponent_health_in = 3'd3; cyc(1);
        check("lose_entry", game_state_out, 2'd3);

        // Fade-in on LOSE.
        cyc(2);
        check("lose_fade4", pixel_out, 24'h0F0F0F);
        for (int i = 0; i < 4; i++) begin
            frame(); cyc(2);
            check("lose_fade_step", pixel_out, fade_exp[i]);
        end
        frame(); cyc(2);
        check("fade_floor", pixel_out, 24'hF0F0F0);

        // Back to PLAY and sweep a line.
        ir_in = RESTART_CODE; cyc(1);
        ir_in = START_CODE_A; cyc(1); ir_in = 32'h0;
        check("play_again", game_state_out, 2'd1);
        for (int i = 0; i < 20; i++) begin
            hcount_in = 11'(300 + i);
            cyc(1);
        end
        check("sweep_latency", hcount_out, 11'd318);

        // Asynchronous reset mid-line.
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_pixel", pixel_out, 24'h0);
        check("async_rst_hcount", hcount_out, 11'd0);
        check("async_rst_vcount", vcount_out, 10'd0);
        check("async_rst_state", game_state_out, 2'd0);
        check("async_rst_play", play_active_out, 1'b0);
        cyc(1);
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) check("post_rst_empty", hcount_out, 11'd0);
            if (i >= 2) check("post_rst_latency", hcount_out, 11'(200 + i - 2));
            hcount_in = 11'(200 + i);
            cyc(1);
        end
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
